// File: rtl/stream_accum_pkg.sv
// stream_accum_pkg: shared constants, FSM states and saturating counter helper
package stream_accum_pkg;
    localparam int W_DEFAULT = 16;
    localparam int CNT_W_DEFAULT = 8;
    typedef enum logic {ACC, HOLD} state_e;
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc, input logic [31:0] max);
        return (inc && v != max) ? v + 32'd1 : v;
    endfunction
endpackage

// File: rtl/stream_accum16_if.sv
// stream_accum16_if: input word stream and frame result handshakes
interface stream_accum16_if
    import stream_accum_pkg::*;
#(
    parameter int W = W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
);
    logic in_valid;
    logic in_ready;
    logic [W-1:0] in_data;
    logic in_last;
    logic out_valid;
    logic out_ready;
    logic [W-1:0] out_sum;
    logic [CNT_W-1:0] out_carries;
    logic [CNT_W-1:0] out_count;
    logic out_ovf;
    modport master(
        output in_valid, in_data, in_last, out_ready,
        input in_ready, out_valid, out_sum, out_carries, out_count, out_ovf
    );
    modport slave(
        input in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_carries, out_count, out_ovf
    );
endinterface

// File: rtl/ks_add16.sv
// ks_add16: 16-bit Kogge-Stone adder with carry-in, 17-bit result
module ks_add16 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        cin,
    output logic [16:0] S
);
    logic [15:0] g, p, gn, pn, hp;
    always_comb begin
        hp = A ^ B;
        g = (A & B) | {15'b0, hp[0] & cin};
        p = hp;
        for (int l = 0; l < 4; l++) begin
            gn = g;
            pn = p;
            for (int i = 1 << l; i < 16; i++) begin
                gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                pn[i] = p[i] & p[i - (1 << l)];
            end
            g = gn;
            p = pn;
        end
        S = {g[15], hp ^ {g[14:0], cin}};
    end
endmodule

// File: rtl/stream_accum16.sv
// stream_accum16: frame accumulator folding each word through ks_add16, counting carries
module stream_accum16
    import stream_accum_pkg::*;
#(
    parameter int W = W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input logic clk,
    input logic rst,
    stream_accum16_if.slave bus
);
    state_e state_q, state_d;
    logic [W-1:0] acc_q, acc_d, sum_q, sum_d;
    logic [CNT_W-1:0] car_q, car_d, cnt_q, cnt_d, ocar_q, ocar_d, ocnt_q, ocnt_d;
    logic ovf_q, ovf_d, oovf_q, oovf_d;
    logic [W:0] s;
    ks_add16 u_add (.A(acc_q), .B(bus.in_data), .cin(1'b0), .S(s));
    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        car_d = car_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        sum_d = sum_q;
        ocar_d = ocar_q;
        ocnt_d = ocnt_q;
        oovf_d = oovf_q;
        if (state_q == ACC && bus.in_valid) begin
            acc_d = s[W-1:0];
            car_d = CNT_W'(sat_inc(32'(car_q), s[W], 32'({CNT_W{1'b1}})));
            cnt_d = CNT_W'(sat_inc(32'(cnt_q), 1'b1, 32'({CNT_W{1'b1}})));
            ovf_d = ovf_q | (s[W] & (&car_q)) | (&cnt_q);
            if (bus.in_last) begin
                sum_d = acc_d;
                ocar_d = car_d;
                ocnt_d = cnt_d;
                oovf_d = ovf_d;
                state_d = HOLD;
            end
        end else if (state_q == HOLD && bus.out_ready) begin
            acc_d = '0;
            car_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            state_d = ACC;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            acc_q <= '0;
            car_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            sum_q <= '0;
            ocar_q <= '0;
            ocnt_q <= '0;
            oovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            car_q <= car_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            sum_q <= sum_d;
            ocar_q <= ocar_d;
            ocnt_q <= ocnt_d;
            oovf_q <= oovf_d;
        end
    end
    assign bus.in_ready = state_q == ACC;
    assign bus.out_valid = state_q == HOLD;
    assign bus.out_sum = sum_q;
    assign bus.out_carries = ocar_q;
    assign bus.out_count = ocnt_q;
    assign bus.out_ovf = oovf_q;
endmodule

// File: tb/tb_stream_accum16.sv
// tb_stream_accum16: directed and randomized frames against an arithmetic frame-sum model
module tb_stream_accum16;
    logic clk = 1'b0;
    logic rst;
    int n_chk = 0;
    int n_pass = 0;
    always #5 clk = ~clk;
    stream_accum16_if #(.W(16), .CNT_W(8)) b0 ();
    stream_accum16_if #(.W(16), .CNT_W(2)) b1 ();
    stream_accum16 #(.W(16), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    stream_accum16 #(.W(16), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        int k = 0;
        b0.in_valid = 1'b1;
        b0.in_data = d;
        b0.in_last = last;
        while (!b0.in_ready && k < 20) begin
            step();
            k++;
        end
        if (k == 20) chk("send_timeout", 32'(k), 32'd0);
        step();
        b0.in_valid = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input logic [15:0] sum, input logic [7:0] car,
                                input logic [7:0] cnt, input logic ovf);
        chk({tag, "_valid"}, 32'(b0.out_valid), 32'd1);
        chk({tag, "_ready"}, 32'(b0.in_ready), 32'd0);
        chk({tag, "_sum"}, 32'(b0.out_sum), 32'(sum));
        chk({tag, "_car"}, 32'(b0.out_carries), 32'(car));
        chk({tag, "_cnt"}, 32'(b0.out_count), 32'(cnt));
        chk({tag, "_ovf"}, 32'(b0.out_ovf), 32'(ovf));
    endtask

    task automatic complete(input string tag);
        b0.out_ready = 1'b1;
        step();
        b0.out_ready = 1'b0;
        chk({tag, "_done_valid"}, 32'(b0.out_valid), 32'd0);
        chk({tag, "_done_ready"}, 32'(b0.in_ready), 32'd1);
    endtask

    initial begin
        longint total;
        int n, len, wait_c;
        logic [15:0] d;
        logic [15:0] sum0;
        rst = 1'b1;
        {b0.in_valid, b0.in_data, b0.in_last, b0.out_ready} = '0;
        {b1.in_valid, b1.in_data, b1.in_last, b1.out_ready} = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 32'(b0.in_ready), 32'd1);
        chk("rst_valid", 32'(b0.out_valid), 32'd0);
        chk("rst_sum", 32'(b0.out_sum), 32'd0);
        chk("rst_car", 32'(b0.out_carries), 32'd0);
        chk("rst_cnt", 32'(b0.out_count), 32'd0);
        chk("rst_ovf", 32'(b0.out_ovf), 32'd0);

        send(16'h1234, 1'b1);
        expect_frame("single", 16'h1234, 8'd0, 8'd1, 1'b0);
        complete("single");
        chk("single_hold_sum", 32'(b0.out_sum), 32'h1234);

        send(16'hFFFF, 1'b0);
        send(16'h0001, 1'b1);
        expect_frame("wrap", 16'h0000, 8'd1, 8'd2, 1'b0);
        complete("wrap");

        send(16'h0005, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ready", 32'(b0.in_ready), 32'd0);
            chk("bp_valid", 32'(b0.out_valid), 32'd1);
            chk("bp_sum", 32'(b0.out_sum), 32'h5);
            chk("bp_cnt", 32'(b0.out_count), 32'd1);
        end
        complete("bp");

        send(16'h00FF, 1'b0);
        send(16'h0F00, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_ready", 32'(b0.in_ready), 32'd1);
        chk("mrst_valid", 32'(b0.out_valid), 32'd0);
        chk("mrst_sum", 32'(b0.out_sum), 32'd0);
        chk("mrst_cnt", 32'(b0.out_count), 32'd0);
        send(16'h0002, 1'b1);
        expect_frame("mrst", 16'h0002, 8'd0, 8'd1, 1'b0);
        complete("mrst");

        b1.in_valid = 1'b1;
        b1.in_data = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            b1.in_last = (i == 4);
            step();
        end
        b1.in_valid = 1'b0;
        chk("sat_valid", 32'(b1.out_valid), 32'd1);
        chk("sat_sum", 32'(b1.out_sum), 32'hFFFB);
        chk("sat_car", 32'(b1.out_carries), 32'd3);
        chk("sat_cnt", 32'(b1.out_count), 32'd3);
        chk("sat_ovf", 32'(b1.out_ovf), 32'd1);
        b1.out_ready = 1'b1;
        step();
        b1.out_ready = 1'b0;
        b1.in_valid = 1'b1;
        b1.in_data = 16'h0001;
        b1.in_last = 1'b1;
        step();
        b1.in_valid = 1'b0;
        chk("sat_clr_ovf", 32'(b1.out_ovf), 32'd0);
        chk("sat_clr_cnt", 32'(b1.out_count), 32'd1);

        send(16'h0007, 1'b1);
        b0.out_ready = 1'b1;
        b0.in_valid = 1'b1;
        b0.in_data = 16'h0010;
        b0.in_last = 1'b0;
        step();
        chk("b2b_gap_valid", 32'(b0.out_valid), 32'd0);
        chk("b2b_gap_ready", 32'(b0.in_ready), 32'd1);
        step();
        b0.in_data = 16'h0020;
        b0.in_last = 1'b1;
        step();
        b0.in_valid = 1'b0;
        chk("b2b_valid", 32'(b0.out_valid), 32'd1);
        chk("b2b_sum", 32'(b0.out_sum), 32'h30);
        chk("b2b_cnt", 32'(b0.out_count), 32'd2);
        chk("b2b_car", 32'(b0.out_carries), 32'd0);
        step();
        b0.out_ready = 1'b0;

        for (int f = 0; f < 21; f++) begin
            len = (f == 20) ? 300 : int'($urandom_range(1, 6));
            total = 0;
            n = 0;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(3) == 0) step();
                d = 16'($urandom);
                total += longint'(d);
                n++;
                send(d, i == len - 1);
            end
            sum0 = 16'(total);
            expect_frame("rnd", sum0, ((total >> 16) > 255) ? 8'd255 : 8'(total >> 16),
                         (n > 255) ? 8'd255 : 8'(n), ((total >> 16) > 255) || (n > 255));
            wait_c = $urandom_range(0, 3);
            for (int i = 0; i < wait_c; i++) step();
            chk("rnd_held", 32'(b0.out_sum), 32'(sum0));
            complete("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/stream_accum16.md
Name: stream_accum16

Overview:
- Streaming multi-operand accumulator that sits directly downstream of the 16-bit adder (sum S[16:0], S = A + B).
- Accepts a frame of 16-bit words over a valid/ready handshake and feeds each word with the running accumulator into the adder.
- Folds the 17-bit result back into the accumulator, counting carry-outs, and presents the frame total on an output handshake.
- Together, the low sum and the carry count give the full-precision frame sum: total = out_carries*2^16 + out_sum.

Parameters:
- W, 16, operand/accumulator width; must match adder width.
- CNT_W, 8, width of the beat counter and carry counter; both saturate.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  W  operand word.
- in_last  input  1  qualifies final word of frame (sampled with in_valid).
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  W  low W bits of frame sum.
- out_carries  output  CNT_W  number of adder carry-outs in frame (saturating).
- out_count  output  CNT_W  beats accepted in frame (saturating).
- out_ovf  output  1  sticky-per-frame flag: carry or beat counter saturated.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - State goes to ACC; acc, carries, count and ovf are cleared.
  - in_ready=1 from the first cycle after reset.
  - out_valid=0; out_sum, out_carries and out_count are 0; out_ovf=0.
  - rst has priority over every other event, including a mid-frame reset or a reset while HOLD is waiting on out_ready; a partial frame is discarded.
- States: ACC, HOLD.
- ACC:
  - in_ready=1 and out_valid=0.
  - Beat accepted when in_valid & in_ready.
  - On a beat, the adder computes S = acc + in_data, with cin tied 0.
  - acc <= S[W-1:0].
  - carries <= carries + S[W], saturating at 2^CNT_W-1; out_ovf is set if an increment is lost.
  - count <= count + 1, with the same saturation; out_ovf is set if an increment is lost.
  - Beat with in_last=1: outputs load the post-update values (S[W-1:0], updated carries, count, ovf). State moves to HOLD and out_valid=1 on the next cycle. Latency is therefore 1 cycle from last-beat acceptance to out_valid.
  - in_valid=0: no change.
- HOLD:
  - in_ready=0 and out_valid=1.
  - Outputs are held stable until out_ready=1; the handshake completes on out_valid & out_ready.
  - On completion: acc, carries, count and ovf are cleared, state returns to ACC, out_valid=0 and in_ready=1 on the next cycle. Minimum gap between frames is 1 cycle.
- Output data values after a completed handshake: hold last values (don't-care to downstream, but deterministic).
- Frames always contain at least one beat; an empty frame is not representable.
- Accumulator wrap: the low W bits wrap modulo 2^W; every wrap is counted in carries.
- in_data/in_last are ignored when in_ready=0.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.

Decomposition:
- Shared package stream_accum_pkg holds:
  - constants W_DEFAULT=16 and CNT_W_DEFAULT=8;
  - state enum {ACC, HOLD};
  - a saturating-increment function used for both counters.
- One sub-module, ks_add16: the 16-bit adder with ports A, B, cin, S[16:0], instantiated once with cin=0. The control FSM and registers stay in stream_accum16.

Test Plan:
- Single beat 0x1234, last=1 -> next cycle: out_valid=1, out_sum=0x1234, out_carries=0, out_count=1, out_ovf=0.
- Frame {0xFFFF, 0x0001(last)} -> out_sum=0x0000, out_carries=1, out_count=2, out_ovf=0.
- Backpressure: result pending, out_ready=0 for 3 cycles -> in_ready=0 and outputs unchanged all 3 cycles. Then out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Reset mid-frame:
  - Accept 0x00FF, 0x0F00, then assert rst for 1 cycle -> all outputs 0, in_ready=1.
  - Then frame {0x0002(last)} -> out_sum=0x0002, out_count=1.
- Saturation with CNT_W=2: five beats of 0xFFFF, last on the 5th -> out_sum=0xFFFB, out_carries=3, out_count=3, out_ovf=1.
- Back-to-back: out_ready held 1 while a new frame {0x0010, 0x0020(last)} is presented continuously -> out_sum=0x0030 and count=2. No beat is accepted while in HOLD, and no beat is lost or duplicated.
